// File: rtl/event_counter_bank_pkg.sv
// Shared definitions for the event counter bank: default width, mode encodings,
// per-channel update decode and a select-width helper.
package event_counter_bank_pkg;

    localparam int COUNTER_WIDTH = 10;
    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } ch_op_e;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/event_counter_ch.sv
// One up/down event counter channel: priority update, bound detection,
// sticky overflow/underflow flags and a registered one-cycle wrap pulse.
module event_counter_ch
    import event_counter_bank_pkg::*;
#(
    parameter int WIDTH    = COUNTER_WIDTH,
    parameter int SATURATE = CNT_MODE_WRAP
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             flag_clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    ch_op_e           op;

    // Simultaneous inc and dec cancel out and fall through to hold.
    always_comb begin
        op = OP_HOLD;
        if (clr_i)
            op = OP_CLR;
        else if (load_i)
            op = OP_LOAD;
        else if (inc_i && !dec_i)
            op = OP_INC;
        else if (dec_i && !inc_i)
            op = OP_DEC;
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q & ~flag_clr_i;
        unf_d   = unf_q & ~flag_clr_i;
        case (op)
            OP_CLR:  count_d = '0;
            OP_LOAD: count_d = load_val_i;
            OP_INC: begin
                if (count_q == MAX_VAL) begin
                    count_d = (SATURATE == CNT_MODE_SAT) ? MAX_VAL : '0;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            OP_DEC: begin
                if (count_q == '0) begin
                    count_d = (SATURATE == CNT_MODE_SAT) ? '0 : MAX_VAL;
                    wrap_d  = 1'b1;
                    unf_d   = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/event_counter_bank.sv
// Bank of NUM_CH independent event counters with load decode, a coherent
// all-channel snapshot register and per-channel threshold compare.
module event_counter_bank
    import event_counter_bank_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = COUNTER_WIDTH,
    parameter int SATURATE = CNT_MODE_WRAP
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_CH-1:0]             inc_i,
    input  logic [NUM_CH-1:0]             dec_i,
    input  logic [NUM_CH-1:0]             clr_i,
    input  logic                          load_en_i,
    input  logic [sel_width(NUM_CH)-1:0]  load_ch_i,
    input  logic [WIDTH-1:0]              load_val_i,
    input  logic [WIDTH-1:0]              thresh_i,
    input  logic                          snap_i,
    input  logic [NUM_CH-1:0]             flag_clr_i,
    output logic [NUM_CH*WIDTH-1:0]       count_o,
    output logic [NUM_CH*WIDTH-1:0]       snap_o,
    output logic [NUM_CH-1:0]             thr_o,
    output logic [NUM_CH-1:0]             wrap_o,
    output logic [NUM_CH-1:0]             ovf_o,
    output logic [NUM_CH-1:0]             unf_o
);

    logic [NUM_CH-1:0]       load_sel;
    logic [NUM_CH*WIDTH-1:0] snap_q, snap_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Out-of-range channel numbers match no channel and are dropped.
        assign load_sel[gi] = load_en_i && (32'(load_ch_i) == 32'(gi));

        event_counter_ch #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .CLK        (CLK),
            .RST        (RST),
            .inc_i      (inc_i[gi]),
            .dec_i      (dec_i[gi]),
            .clr_i      (clr_i[gi]),
            .load_i     (load_sel[gi]),
            .load_val_i (load_val_i),
            .flag_clr_i (flag_clr_i[gi]),
            .count_o    (count_o[gi*WIDTH +: WIDTH]),
            .wrap_o     (wrap_o[gi]),
            .ovf_o      (ovf_o[gi]),
            .unf_o      (unf_o[gi])
        );

        assign thr_o[gi] = (count_o[gi*WIDTH +: WIDTH] >= thresh_i);
    end

    // Snapshot takes the counts visible this cycle, before this edge's update.
    always_comb begin
        snap_d = snap_q;
        if (snap_i)
            snap_d = count_o;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            snap_q <= '0;
        else
            snap_q <= snap_d;
    end

    assign snap_o = snap_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Randomized scoreboard bench: a wrap-mode and a saturate-mode bank share stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_event_counter_bank;

    localparam int NCH = 4;
    localparam int W   = 10;
    localparam int MAXV = (1 << W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [NCH-1:0]   inc_i = '0, dec_i = '0, clr_i = '0, flag_clr_i = '0;
    logic             load_en_i = 1'b0, snap_i = 1'b0;
    logic [1:0]       load_ch_i = '0;
    logic [W-1:0]     load_val_i = '0, thresh_i = '0;

    logic [NCH*W-1:0] cnt_a [2];
    logic [NCH*W-1:0] snp_a [2];
    logic [NCH-1:0]   thr_a [2];
    logic [NCH-1:0]   wrp_a [2];
    logic [NCH-1:0]   ovf_a [2];
    logic [NCH-1:0]   unf_a [2];

    always #5 CLK = ~CLK;

    event_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(0)) u_wrap (
        .CLK(CLK), .RST(RST), .inc_i(inc_i), .dec_i(dec_i), .clr_i(clr_i),
        .load_en_i(load_en_i), .load_ch_i(load_ch_i), .load_val_i(load_val_i),
        .thresh_i(thresh_i), .snap_i(snap_i), .flag_clr_i(flag_clr_i),
        .count_o(cnt_a[0]), .snap_o(snp_a[0]), .thr_o(thr_a[0]),
        .wrap_o(wrp_a[0]), .ovf_o(ovf_a[0]), .unf_o(unf_a[0])
    );

    event_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(1)) u_sat (
        .CLK(CLK), .RST(RST), .inc_i(inc_i), .dec_i(dec_i), .clr_i(clr_i),
        .load_en_i(load_en_i), .load_ch_i(load_ch_i), .load_val_i(load_val_i),
        .thresh_i(thresh_i), .snap_i(snap_i), .flag_clr_i(flag_clr_i),
        .count_o(cnt_a[1]), .snap_o(snp_a[1]), .thr_o(thr_a[1]),
        .wrap_o(wrp_a[1]), .ovf_o(ovf_a[1]), .unf_o(unf_a[1])
    );

    typedef struct {
        int                       id;
        logic [1:0][NCH*W-1:0]    cnt;
        logic [1:0][NCH*W-1:0]    snp;
        logic [1:0][NCH-1:0]      thr;
        logic [1:0][NCH-1:0]      wrp;
        logic [1:0][NCH-1:0]      ovf;
        logic [1:0][NCH-1:0]      unf;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   txn_id = 0;

    // Reference state, index [mode][channel]; mode 0 = wrap, 1 = saturate.
    int m_cnt [2][NCH];
    int m_snp [2][NCH];
    bit m_ovf [2][NCH];
    bit m_unf [2][NCH];

    task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h", name, m, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < NCH; k++) begin
                m_cnt[m][k] = 0; m_snp[m][k] = 0; m_ovf[m][k] = 0; m_unf[m][k] = 0;
            end
    endtask

    task automatic drive(input logic [NCH-1:0] inc, input logic [NCH-1:0] dec,
                         input logic [NCH-1:0] clr, input logic ld_en, input logic [1:0] ld_ch,
                         input logic [W-1:0] ld_val, input logic [W-1:0] thr,
                         input logic snap, input logic [NCH-1:0] fclr);
        exp_t e;
        @(negedge CLK);
        inc_i = inc; dec_i = dec; clr_i = clr; load_en_i = ld_en; load_ch_i = ld_ch;
        load_val_i = ld_val; thresh_i = thr; snap_i = snap; flag_clr_i = fclr;
        e.id = txn_id++;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NCH; k++) begin
                int  pre = m_cnt[m][k];
                int  nxt = pre;
                bit  wrap_ev = 0;
                if (snap) m_snp[m][k] = pre;
                if (fclr[k]) begin m_ovf[m][k] = 0; m_unf[m][k] = 0; end
                if (clr[k]) nxt = 0;
                else if (ld_en && int'(ld_ch) == k) nxt = int'(ld_val);
                else if (inc[k] && !dec[k]) begin
                    nxt = pre + 1;
                    if (nxt > MAXV) begin
                        nxt = (m == 1) ? MAXV : nxt - (MAXV + 1);
                        wrap_ev = 1; m_ovf[m][k] = 1;
                    end
                end else if (dec[k] && !inc[k]) begin
                    nxt = pre - 1;
                    if (nxt < 0) begin
                        nxt = (m == 1) ? 0 : nxt + (MAXV + 1);
                        wrap_ev = 1; m_unf[m][k] = 1;
                    end
                end
                m_cnt[m][k] = nxt;
                e.cnt[m][k*W +: W] = W'(nxt);
                e.snp[m][k*W +: W] = W'(m_snp[m][k]);
                e.thr[m][k] = (nxt >= int'(thr));
                e.wrp[m][k] = wrap_ev;
                e.ovf[m][k] = m_ovf[m][k];
                e.unf[m][k] = m_unf[m][k];
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive('0, '0, '0, 1'b0, 2'd0, '0, thresh_i, 1'b0, '0);
    endtask

    task automatic rand_cycle();
        logic [NCH-1:0] inc, dec, clr, fclr;
        logic [W-1:0]   val, thr;
        for (int k = 0; k < NCH; k++) begin
            inc[k]  = ($urandom_range(0, 2) != 0);
            dec[k]  = ($urandom_range(0, 2) == 0);
            clr[k]  = ($urandom_range(0, 19) == 0);
            fclr[k] = ($urandom_range(0, 9) == 0);
        end
        case ($urandom_range(0, 4))
            0: val = '0;
            1: val = W'(MAXV);
            2: val = W'(MAXV - 1);
            3: val = W'(1);
            default: val = W'($urandom);
        endcase
        thr = ($urandom_range(0, 3) == 0) ? W'(MAXV) : W'($urandom);
        drive(inc, dec, clr, ($urandom_range(0, 2) == 0), 2'($urandom), val, thr,
              ($urandom_range(0, 5) == 0), fclr);
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            logic [NCH-1:0] thr_exp;
            for (int k = 0; k < NCH; k++) thr_exp[k] = (0 >= int'(thresh_i));
            chk({tag, "_count"}, m, 64'(cnt_a[m]), 64'(0));
            chk({tag, "_snap"},  m, 64'(snp_a[m]), 64'(0));
            chk({tag, "_wrap"},  m, 64'(wrp_a[m]), 64'(0));
            chk({tag, "_ovf"},   m, 64'(ovf_a[m]), 64'(0));
            chk({tag, "_unf"},   m, 64'(unf_a[m]), 64'(0));
            chk({tag, "_thr"},   m, 64'(thr_a[m]), 64'(thr_exp));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge CLK);
            #2;
            guard++;
        end
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: every cycle the DUTs present a result, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int m = 0; m < 2; m++) begin
                    chk("count", m, 64'(cnt_a[m]), 64'(e.cnt[m]));
                    chk("snap",  m, 64'(snp_a[m]), 64'(e.snp[m]));
                    chk("thr",   m, 64'(thr_a[m]), 64'(e.thr[m]));
                    chk("wrap",  m, 64'(wrp_a[m]), 64'(e.wrp[m]));
                    chk("ovf",   m, 64'(ovf_a[m]), 64'(e.ovf[m]));
                    chk("unf",   m, 64'(unf_a[m]), 64'(e.unf[m]));
                end
                $display("txn %0d cnt_wrap=%h cnt_sat=%h wrap=%b/%b", e.id,
                         cnt_a[0], cnt_a[1], wrp_a[0], wrp_a[1]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #3;
        check_reset_state("por");
        @(negedge CLK);
        RST = 1'b1;

        // Five increments on ch0, threshold 5.
        for (int i = 0; i < 5; i++) drive(4'b0001, '0, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, '0);
        // Bound on ch2: load max, increment, decrement.
        drive('0, '0, '0, 1'b1, 2'd2, 10'd1023, 10'd5, 1'b0, '0);
        drive(4'b0100, '0, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, '0);
        drive('0, 4'b0100, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, '0);
        idle(1);
        // Sticky flag on ch1: set wins over clear, then clear alone.
        drive('0, '0, '0, 1'b1, 2'd1, 10'd1023, 10'd5, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(4'b0010, '0, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, '0);
        drive(4'b0010, '0, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, 4'b0010);
        drive('0, '0, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, 4'b0010);
        // Priority on ch3.
        drive(4'b1000, '0, 4'b1000, 1'b1, 2'd3, 10'd200, 10'd5, 1'b0, '0);
        drive(4'b1000, '0, '0, 1'b1, 2'd3, 10'd200, 10'd5, 1'b0, '0);
        drive(4'b1000, 4'b1000, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, '0);
        // Snapshot captures the pre-update count.
        drive('0, '0, '0, 1'b1, 2'd0, 10'd7, 10'd5, 1'b0, '0);
        drive(4'b0001, '0, '0, 1'b0, 2'd0, '0, 10'd5, 1'b1, '0);
        drive(4'b0001, '0, '0, 1'b0, 2'd0, '0, 10'd5, 1'b0, '0);
        idle(2);

        for (int i = 0; i < 500; i++) rand_cycle();

        // Asynchronous reset mid-increment with ch0=300 and flags set.
        drive('0, '0, '0, 1'b1, 2'd0, 10'd1023, 10'd0, 1'b0, '0);
        drive(4'b0001, '0, '0, 1'b0, 2'd0, '0, 10'd0, 1'b0, '0);
        drive('0, 4'b0010, 4'b0010, 1'b1, 2'd0, 10'd300, 10'd0, 1'b0, '0);
        drive('0, 4'b0010, '0, 1'b0, 2'd0, '0, 10'd0, 1'b0, '0);
        drain();
        @(negedge CLK);
        inc_i = 4'b0001; dec_i = '0; clr_i = '0; load_en_i = 1'b0; snap_i = 1'b0;
        flag_clr_i = '0; thresh_i = 10'd3;
        #2;
        RST = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge CLK);
        inc_i = '0;
        model_reset();
        RST = 1'b1;
        drive(4'b0001, '0, '0, 1'b0, 2'd0, '0, 10'd3, 1'b0, '0);

        for (int i = 0; i < 150; i++) rand_cycle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
